// File: rtl/hermes_tp_pkg.sv
// Shared definitions for the Hermes test-packet format.
// The packet injector uses the same package.
package hermes_tp_pkg;

  // Index of each fixed field within a packet, counted in accepted flits.
  localparam int unsigned K_HDR           = 0;
  localparam int unsigned K_SIZE          = 1;
  localparam int unsigned K_STAMP         = 2;
  localparam int unsigned K_PKTNUM        = 3;
  localparam int unsigned K_FIRST_PAYLOAD = 4;

  typedef struct packed {
    logic dest;
    logic short_pkt;
    logic len;
    logic payload;
  } err_flags_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIZE,
    ST_STAMP,
    ST_PKTNUM,
    ST_PAYLOAD
  } sink_state_t;

endpackage

// File: rtl/hermes_pkt_sink.sv
// Hermes local-port packet sink: parses test packets, checks them and
// emits one result record per packet over a valid/ready handshake.
import hermes_tp_pkg::*;

module hermes_pkt_sink #(
  parameter int FLIT_WIDTH = 32,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  input  logic                  eop_i,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  input  logic [31:0]           now_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [15:0]           res_src_o,
  output logic [31:0]           res_size_o,
  output logic [31:0]           res_pkt_num_o,
  output logic [31:0]           res_latency_o,
  output logic [3:0]            res_err_o,
  output logic [31:0]           pkts_recv_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  localparam logic [7:0] MY_X8 = MY_X[7:0];
  localparam logic [7:0] MY_Y8 = MY_Y[7:0];

  // Handshake: a flit moves when rx_i && credit_o at a rising edge; a
  // result moves when res_valid_o && res_ready_i at a rising edge.
  sink_state_t           state_q, state_d;
  logic [31:0]           idx_q, idx_d;
  logic                  over_q, over_d;
  logic [15:0]           src_q, src_d;
  logic [31:0]           size_q, size_d;
  logic [31:0]           lat_q, lat_d;
  logic [31:0]           pkt_q, pkt_d;
  err_flags_t            err_q, err_d;
  logic                  res_valid_q, res_valid_d;
  logic [15:0]           res_src_q, res_src_d;
  logic [31:0]           res_size_q, res_size_d;
  logic [31:0]           res_pkt_q, res_pkt_d;
  logic [31:0]           res_lat_q, res_lat_d;
  err_flags_t            res_err_q, res_err_d;
  logic [31:0]           pkts_q, pkts_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic        acc;
  logic        close;
  logic [32:0] k33;
  logic [32:0] last33;

  assign credit_o = rst_n && !(state_q == ST_IDLE && res_valid_q && !res_ready_i);
  assign acc      = rx_i && credit_o;
  assign k33      = {1'b0, idx_q};
  assign last33   = {1'b0, size_q} + 33'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    over_d      = over_q;
    src_d       = src_q;
    size_d      = size_q;
    lat_d       = lat_q;
    pkt_d       = pkt_q;
    err_d       = err_q;
    close       = 1'b0;
    res_valid_d = res_valid_q;
    res_src_d   = res_src_q;
    res_size_d  = res_size_q;
    res_pkt_d   = res_pkt_q;
    res_lat_d   = res_lat_q;
    res_err_d   = res_err_q;
    pkts_d      = pkts_q;
    err_cnt_d   = err_cnt_q;

    if (acc) begin
      case (state_q)
        ST_IDLE: begin
          // A new packet starts from zeroed fields so early-closed packets report 0.
          src_d    = data_i[31:16];
          size_d   = '0;
          lat_d    = '0;
          pkt_d    = '0;
          err_d    = '0;
          err_d.dest = (data_i[15:8] != MY_X8) || (data_i[7:0] != MY_Y8);
          idx_d    = 32'(K_SIZE);
          state_d  = ST_SIZE;
        end
        ST_SIZE: begin
          size_d  = data_i;
          idx_d   = 32'(K_STAMP);
          state_d = ST_STAMP;
        end
        ST_STAMP: begin
          lat_d   = now_i - data_i;
          idx_d   = 32'(K_PKTNUM);
          state_d = ST_PKTNUM;
        end
        default: begin
          if (state_q == ST_PKTNUM) begin
            pkt_d = data_i;
          end else if (!over_q && data_i != idx_q - 32'd1) begin
            err_d.payload = 1'b1;
          end
          // Beyond the last expected flit everything is discarded until eop.
          if (!over_q) begin
            if (eop_i) begin
              if (k33 != last33) err_d.len = 1'b1;
            end else if (k33 >= last33) begin
              err_d.len = 1'b1;
              over_d    = 1'b1;
            end
            idx_d = idx_q + 32'd1;
          end
          state_d = ST_PAYLOAD;
        end
      endcase

      if (eop_i) begin
        close = 1'b1;
        if (state_q == ST_IDLE || state_q == ST_SIZE || state_q == ST_STAMP) begin
          err_d.short_pkt = 1'b1;
        end
        state_d = ST_IDLE;
        idx_d   = '0;
        over_d  = 1'b0;
      end
    end

    if (close) begin
      res_valid_d = 1'b1;
      res_src_d   = src_d;
      res_size_d  = size_d;
      res_pkt_d   = pkt_d;
      res_lat_d   = lat_d;
      res_err_d   = err_d;
      pkts_d      = pkts_q + 32'd1;
      if (err_d != '0 && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      over_q      <= 1'b0;
      src_q       <= '0;
      size_q      <= '0;
      lat_q       <= '0;
      pkt_q       <= '0;
      err_q       <= '0;
      res_valid_q <= 1'b0;
      res_src_q   <= '0;
      res_size_q  <= '0;
      res_pkt_q   <= '0;
      res_lat_q   <= '0;
      res_err_q   <= '0;
      pkts_q      <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      over_q      <= over_d;
      src_q       <= src_d;
      size_q      <= size_d;
      lat_q       <= lat_d;
      pkt_q       <= pkt_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      res_size_q  <= res_size_d;
      res_pkt_q   <= res_pkt_d;
      res_lat_q   <= res_lat_d;
      res_err_q   <= res_err_d;
      pkts_q      <= pkts_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign res_valid_o   = res_valid_q;
  assign res_src_o     = res_src_q;
  assign res_size_o    = res_size_q;
  assign res_pkt_num_o = res_pkt_q;
  assign res_latency_o = res_lat_q;
  assign res_err_o     = res_err_q;
  assign pkts_recv_o   = pkts_q;
  assign err_cnt_o     = err_cnt_q;

endmodule
